// File: rtl/hazard_ctrl_if.sv
// Memory handshake bundle between the hazard scheduler and the M-stage data memory.
// Ports: mem_req (ctrl->mem), mem_err (ctrl->mem), mem_ready (mem->ctrl).
`ifndef IROP
`define IROP  6'h00
`endif
`ifndef IADDI
`define IADDI 6'h08
`endif
`ifndef IANDI
`define IANDI 6'h0c
`endif
`ifndef IORI
`define IORI  6'h0d
`endif
`ifndef ILW
`define ILW   6'h23
`endif
`ifndef ISW
`define ISW   6'h2b
`endif

interface hazard_mem_if;
  logic mem_req;
  logic mem_err;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_err,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_err,
    output mem_ready
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline scheduler: dst scoreboard E/M/W, stall/bubble/forward control, mem wait FSM.
// Ports: clk, rst_n, D_op/D_rs/D_rt/d_dstE, e_mispredict, mem (hazard_mem_if.master),
// F/D/E/M_stall, D/E/W_bubble, fwdA, fwdB. Macro HAZARD_CTRL_FWD_EN enables forwarding.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [5:0]   D_op,
  input  logic [4:0]   D_rs,
  input  logic [4:0]   D_rt,
  input  logic [4:0]   d_dstE,
  input  logic         e_mispredict,
  hazard_mem_if.master mem,
  output logic         F_stall,
  output logic         D_stall,
  output logic         E_stall,
  output logic         M_stall,
  output logic         D_bubble,
  output logic         E_bubble,
  output logic         W_bubble,
  output logic [1:0]   fwdA,
  output logic [1:0]   fwdB
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       is_load;
    logic       is_mem;
  } sb_t;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  sb_t e_q, e_d;
  sb_t m_q, m_d;
  sb_t w_q, w_d;
  sb_t dec;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic use_rs, use_rt;
  logic is_lw, is_sw;
  logic src_a, src_b;
  logic a_e, a_m, a_w;
  logic b_e, b_m, b_w;
  logic m_mem, timeout;
  logic mem_stall, mis, lu, data_stall;
  logic [1:0] fwd_a, fwd_b;
  logic unused_sb;

  assign is_lw = (D_op == `ILW);
  assign is_sw = (D_op == `ISW);

  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    unique case (1'b1)
      (D_op == `IROP): begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      is_sw: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      (D_op == `IADDI),
      (D_op == `IANDI),
      (D_op == `IORI),
      is_lw: use_rs = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.is_load = is_lw;
    dec.is_mem  = is_lw | is_sw;
    dec.dst     = d_dstE;
    dec.valid   = (d_dstE != 5'd0) | dec.is_mem;
  end

  // r0 never hazards, so gate the sources up front
  assign src_a = use_rs && (D_rs != 5'd0);
  assign src_b = use_rt && (D_rt != 5'd0);

  assign a_e = src_a && e_q.valid && (e_q.dst == D_rs);
  assign a_m = src_a && m_q.valid && (m_q.dst == D_rs);
  assign a_w = src_a && w_q.valid && (w_q.dst == D_rs);
  assign b_e = src_b && e_q.valid && (e_q.dst == D_rt);
  assign b_m = src_b && m_q.valid && (m_q.dst == D_rt);
  assign b_w = src_b && w_q.valid && (w_q.dst == D_rt);

  assign m_mem   = m_q.valid && m_q.is_mem;
  assign timeout = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // Timeout releases the stall even without mem_ready
  always_comb begin
    if (state_q == S_IDLE)
      mem_stall = m_mem && !mem.mem_ready;
    else
      mem_stall = !mem.mem_ready && !timeout;
  end

  // A flush waits for the memory; E is frozen so it re-presents
  assign mis = e_mispredict && !mem_stall;

`ifdef HAZARD_CTRL_FWD_EN
  assign lu = (a_e || b_e) && e_q.is_load;

  always_comb begin
    fwd_a = 2'd0;
    if (a_e && !e_q.is_load) fwd_a = 2'd1;
    else if (a_m)            fwd_a = 2'd2;
    else if (a_w)            fwd_a = 2'd3;
  end

  always_comb begin
    fwd_b = 2'd0;
    if (b_e && !e_q.is_load) fwd_b = 2'd1;
    else if (b_m)            fwd_b = 2'd2;
    else if (b_w)            fwd_b = 2'd3;
  end

  assign unused_sb = ^{w_q.is_load, w_q.is_mem, m_q.is_load};
`else
  // Without bypass paths, any in-flight producer holds decode
  assign lu    = a_e || a_m || a_w || b_e || b_m || b_w;
  assign fwd_a = 2'd0;
  assign fwd_b = 2'd0;

  assign unused_sb = ^{w_q.is_load, w_q.is_mem,
                       m_q.is_load, e_q.is_load};
`endif

  assign data_stall = lu && !mem_stall && !e_mispredict;

  always_comb begin
    w_d = mem_stall ? '0 : m_q;
    m_d = mem_stall ? m_q : e_q;
    e_d = dec;
    if (mem_stall)
      e_d = e_q;
    else if (mis || data_stall)
      e_d = '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (m_mem && !mem.mem_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (mem.mem_ready || timeout) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      e_q     <= e_d;
      m_q     <= m_d;
      w_q     <= w_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs forced low the instant reset asserts
  assign F_stall  = rst_n && (mem_stall || data_stall);
  assign D_stall  = rst_n && (mem_stall || data_stall);
  assign E_stall  = rst_n && mem_stall;
  assign M_stall  = rst_n && mem_stall;
  assign W_bubble = rst_n && mem_stall;
  assign D_bubble = rst_n && mis;
  assign E_bubble = rst_n && (mis || data_stall);
  assign fwdA     = rst_n ? fwd_a : 2'd0;
  assign fwdB     = rst_n ? fwd_b : 2'd0;

  assign mem.mem_req = rst_n && ((state_q == S_WAIT) || m_mem);
  assign mem.mem_err = rst_n && (state_q == S_WAIT)
                       && !mem.mem_ready && timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (MEM_TIMEOUT=4).
// Expectations follow HAZARD_CTRL_FWD_EN when defined.
`ifndef IROP
`define IROP  6'h00
`endif
`ifndef IADDI
`define IADDI 6'h08
`endif
`ifndef IANDI
`define IANDI 6'h0c
`endif
`ifndef IORI
`define IORI  6'h0d
`endif
`ifndef ILW
`define ILW   6'h23
`endif
`ifndef ISW
`define ISW   6'h2b
`endif

module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] D_op = '0;
  logic [4:0] D_rs = '0;
  logic [4:0] D_rt = '0;
  logic [4:0] d_dstE = '0;
  logic       e_mispredict = 1'b0;
  logic       F_stall, D_stall, E_stall, M_stall;
  logic       D_bubble, E_bubble, W_bubble;
  logic [1:0] fwdA, fwdB;

  int total = 0;
  int bad = 0;

  hazard_mem_if mif ();

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .D_op         (D_op),
    .D_rs         (D_rs),
    .D_rt         (D_rt),
    .d_dstE       (d_dstE),
    .e_mispredict (e_mispredict),
    .mem          (mif.master),
    .F_stall      (F_stall),
    .D_stall      (D_stall),
    .E_stall      (E_stall),
    .M_stall      (M_stall),
    .D_bubble     (D_bubble),
    .E_bubble     (E_bubble),
    .W_bubble     (W_bubble),
    .fwdA         (fwdA),
    .fwdB         (fwdB)
  );

  always #5 clk = ~clk;

  // {F,D,E,M stall, D,E,W bubble, req, err, fwdA, fwdB}
  logic [12:0] outv;
  assign outv = {F_stall, D_stall, E_stall, M_stall,
                 D_bubble, E_bubble, W_bubble,
                 mif.mem_req, mif.mem_err, fwdA, fwdB};

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic        mis;
    logic        rdy;
    logic [12:0] exp;
  } vec_t;

  function automatic logic [12:0] ev(
    input logic f, input logic d, input logic e, input logic m,
    input logic db, input logic eb, input logic wb,
    input logic rq, input logic er,
    input logic [1:0] fa, input logic [1:0] fb);
    return {f, d, e, m, db, eb, wb, rq, er, fa, fb};
  endfunction

  function automatic vec_t mk(
    input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] dst, input logic mis, input logic rdy,
    input logic [12:0] exp);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.dst = dst;
    v.mis = mis; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  localparam logic [12:0] Z  = 13'd0;
  localparam logic [12:0] RQ = 13'b0000000_10_00_00;
  localparam logic [12:0] LU = 13'b1100010_00_00_00;
  localparam logic [12:0] MW = 13'b1111001_10_00_00;

  task automatic drive(input vec_t v);
    D_op = v.op;
    D_rs = v.rs;
    D_rt = v.rt;
    d_dstE = v.dst;
    e_mispredict = v.mis;
    mif.mem_ready = v.rdy;
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) begin
      drive(mk(`IROP, 0, 0, 0, 0, 1, Z));
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    drive(mk(`ILW, 3, 3, 3, 1, 0, Z));
    #2;
    total++;
    if (outv !== Z) begin
      bad++;
      $display("FAIL reset_hold got=%b exp=%b", outv, Z);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(mk(`IROP, 0, 0, 0, 0, 1, Z));
    #2;
    total++;
    if (outv !== Z) begin
      bad++;
      $display("FAIL reset_release got=%b exp=%b", outv, Z);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    vec_t q[$];
    q.push_back(mk(`ILW, 1, 0, 8, 0, 1, Z));
    q.push_back(mk(`IROP, 8, 0, 9, 0, 1, LU));
`ifdef HAZARD_CTRL_FWD_EN
    q.push_back(mk(`IROP, 8, 0, 9, 0, 1, ev(0,0,0,0,0,0,0,1,0,2,0)));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 1, Z));
`else
    q.push_back(mk(`IROP, 8, 0, 9, 0, 1, LU | RQ));
    q.push_back(mk(`IROP, 8, 0, 9, 0, 1, LU));
    q.push_back(mk(`IROP, 8, 0, 9, 0, 1, Z));
`endif
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i]);
      #2;
      total++;
      if (outv !== q[i].exp) begin
        bad++;
        $display("FAIL load_use[%0d] got=%b exp=%b", i, outv, q[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fwd();
    vec_t q[$];
    q.push_back(mk(`IADDI, 1, 0, 5, 0, 1, Z));
`ifdef HAZARD_CTRL_FWD_EN
    q.push_back(mk(`IROP, 5, 5, 6, 0, 1, ev(0,0,0,0,0,0,0,0,0,1,1)));
    q.push_back(mk(`IADDI, 0, 0, 0, 0, 1, Z));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 1, Z));
    q.push_back(mk(`IANDI, 6, 6, 7, 0, 1, ev(0,0,0,0,0,0,0,0,0,3,0)));
`else
    q.push_back(mk(`IROP, 5, 5, 6, 0, 1, LU));
    q.push_back(mk(`IROP, 5, 5, 6, 0, 1, LU));
    q.push_back(mk(`IROP, 5, 5, 6, 0, 1, LU));
    q.push_back(mk(`IROP, 5, 5, 6, 0, 1, Z));
    q.push_back(mk(`IANDI, 0, 6, 7, 0, 1, Z));
`endif
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i]);
      #2;
      total++;
      if (outv !== q[i].exp) begin
        bad++;
        $display("FAIL fwd[%0d] got=%b exp=%b", i, outv, q[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    vec_t q[$];
    q.push_back(mk(`ISW, 2, 3, 0, 0, 1, Z));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 1, Z));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 0, MW));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 0, MW));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 0, MW));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 1, RQ));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 1, Z));
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i]);
      #2;
      total++;
      if (outv !== q[i].exp) begin
        bad++;
        $display("FAIL mem_wait[%0d] got=%b exp=%b", i, outv, q[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    vec_t q[$];
    q.push_back(mk(`ISW, 2, 3, 0, 0, 1, Z));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 1, Z));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 0, MW));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 0, MW));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 0, MW));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 0, MW));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,1,1,0,0)));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 0, Z));
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i]);
      #2;
      total++;
      if (outv !== q[i].exp) begin
        bad++;
        $display("FAIL timeout[%0d] got=%b exp=%b", i, outv, q[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mispredict();
    vec_t q[$];
    q.push_back(mk(`ILW, 1, 0, 8, 0, 1, Z));
    q.push_back(mk(`IROP, 8, 0, 9, 1, 1, ev(0,0,0,0,1,1,0,0,0,0,0)));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 1, RQ));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 1, Z));
    q.push_back(mk(`ILW, 1, 0, 8, 0, 1, Z));
    q.push_back(mk(`IADDI, 1, 0, 4, 0, 1, Z));
    q.push_back(mk(`IROP, 0, 0, 3, 1, 0, MW));
    q.push_back(mk(`IROP, 0, 0, 3, 1, 0, MW));
    q.push_back(mk(`IROP, 0, 0, 3, 1, 1, ev(0,0,0,0,1,1,0,1,0,0,0)));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 1, Z));
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i]);
      #2;
      total++;
      if (outv !== q[i].exp) begin
        bad++;
        $display("FAIL mispredict[%0d] got=%b exp=%b", i, outv, q[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midwait();
    vec_t q[$];
    q.push_back(mk(`ISW, 2, 3, 0, 0, 1, Z));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 1, Z));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 0, MW));
    q.push_back(mk(`IROP, 0, 0, 0, 0, 0, MW));
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i]);
      #2;
      total++;
      if (outv !== q[i].exp) begin
        bad++;
        $display("FAIL rst_wait[%0d] got=%b exp=%b", i, outv, q[i].exp);
      end
      @(posedge clk); #1;
    end
    drive(mk(`IROP, 5, 5, 0, 1, 0, Z));
    rst_n = 1'b0;
    #2;
    total++;
    if (outv !== Z) begin
      bad++;
      $display("FAIL rst_midwait got=%b exp=%b", outv, Z);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(mk(`IROP, 0, 0, 0, 0, 0, Z));
    #2;
    total++;
    if (outv !== Z) begin
      bad++;
      $display("FAIL rst_idle got=%b exp=%b", outv, Z);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    mif.mem_ready = 1'b1;
    #12;
    test_reset();
    flush();
    test_load_use();
    flush();
    test_fwd();
    flush();
    test_mem_wait();
    flush();
    test_timeout();
    flush();
    test_mispredict();
    flush();
    test_reset_midwait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline scheduler for the five-stage MIPS core. It tracks the destination register produced by dstE (d_dstE) as it moves through the E, M and W stages. From that state it drives stall, bubble and forwarding-select controls for the F/D/E/M/W pipeline registers. It also sequences the M-stage memory handshake through a small wait FSM.

Parameters:
MEM_TIMEOUT, 15, max wait cycles for mem_ready before forced completion (1..255)
CNT_W, 8, width of the wait counter

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
D_op  in  6  decode-stage opcode (`IROP, `IADDI, `IANDI, `IORI, `ILW, `ISW)
D_rs  in  5  decode-stage rs field
D_rt  in  5  decode-stage rt field
d_dstE  in  5  decode destination from dstE (0 = no write)
e_mispredict  in  1  branch resolved wrong in E
mem_ready  in  1  data memory completes M-stage access this cycle
F_stall  out  1  hold fetch PC
D_stall  out  1  hold D register
E_stall  out  1  hold E register
M_stall  out  1  hold M register
D_bubble  out  1  load nop into D
E_bubble  out  1  load nop into E
W_bubble  out  1  load nop into W
fwdA  out  2  rs operand select: 0 regfile, 1 E, 2 M, 3 W
fwdB  out  2  rt operand select, same encoding
mem_req  out  1  M-stage memory access request
mem_err  out  1  one-cycle pulse on timeout

Behaviour:
- Scoreboard registers E/M/W each hold {valid, dst[4:0], is_load, is_mem}. Reset value: all 0.
- Scoreboard advance on each edge, stage by stage:
  - W <= M when M is not stalled; otherwise W <= invalid.
  - M <= E unless M_stall.
  - E <= decode info unless E_stall. E <= invalid when E_bubble.
- Decode entry: is_load = (D_op==`ILW); is_mem = `ILW or `ISW. An entry is valid only if d_dstE != 0 or is_mem.
- Source usage: rs is used by every listed op. rt is used only by `IROP and `ISW. Register 0 never creates a hazard.
- Load-use hazard: E.valid && E.is_load && E.dst != 0 && E.dst equals a used source. Response: F_stall=D_stall=1 and E_bubble=1 for exactly one cycle.
- Mispredict: e_mispredict=1 gives D_bubble=E_bubble=1 and F_stall=0. It takes priority over load-use.
- Memory FSM, states IDLE and WAIT:
  - IDLE: when M.valid && M.is_mem, mem_req=1. If mem_ready=1, stay IDLE with no stall. If mem_ready=0, go to WAIT, clear the counter, and assert M_stall/E_stall/D_stall/F_stall and W_bubble in that same cycle.
  - WAIT: mem_req=1 and all stalls plus W_bubble are held; the counter increments each cycle.
  - WAIT exit on mem_ready=1: go to IDLE; stalls drop combinationally that cycle.
  - WAIT exit on timeout (counter == MEM_TIMEOUT-1): pulse mem_err for 1 cycle, go to IDLE, release the stalls (access treated as done).
- Priority: memory wait > mispredict > load-use. A mispredict during WAIT is deferred. E is frozen during WAIT, so e_mispredict stays high and the flush applies in the release cycle.
- Forwarding selects fwdA/fwdB are combinational. For each used source: pick the nearest valid stage with matching non-zero dst, excluding E if E.is_load; else 0. Unused sources give 0.
- Reset: all outputs are 0 while rst_n=0, including mid-WAIT (mem_req drops immediately). FSM returns to IDLE and the counter is cleared.

Optional Feature:
HAZARD_CTRL_FWD_EN
- Defined: forwarding as above; the only data stall is load-use.
- Undefined: fwdA=fwdB=0 always. Any used-source match with a valid E, M or W entry gives F_stall=D_stall=1 and E_bubble=1, repeated until no match remains (up to 3 cycles).

Test Plan:
- Reset: rst_n=0 mid-WAIT -> mem_req=0, all stalls 0, fwd 0 immediately; after release, FSM is IDLE.
- `ILW dst=8, then `IROP rs=8 -> one cycle F_stall=D_stall=E_bubble=1, then fwdA=2 with no further stall.
- `IADDI dst=5, then `IROP rs=5 rt=5 -> fwdA=fwdB=1, no stall. `IADDI dst=0 followed by rs=0 -> fwd 0.
- `ISW in M with mem_ready low for 3 cycles -> M_stall and W_bubble high for 3 cycles, release in the cycle mem_ready=1.
- mem_ready held 0 with MEM_TIMEOUT=4 -> mem_err pulse after 4 WAIT cycles, stalls released.
- e_mispredict during load-use -> D_bubble=E_bubble=1, F_stall=0. During WAIT -> flush occurs in the release cycle.
